// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller:
// FSM state encoding, flag bit positions and the default datapath width.
package serial_alu_pkg;

   localparam int DEFAULT_WIDTH = 64;

   localparam int NEG  = 3;
   localparam int ZERO = 2;
   localparam int OVF  = 1;
   localparam int COUT = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/addSub.sv
// One-bit add/subtract slice: computes a + (b ^ sub) + cin and its carry out.
module addSub (
   input  logic i_a,
   input  logic i_b,
   input  logic i_sub,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   logic w_b_eff;

   assign w_b_eff = i_b ^ i_sub;
   assign o_sum   = i_a ^ w_b_eff ^ i_cin;
   assign o_cout  = (i_a & w_b_eff) | (i_a & i_cin) | (w_b_eff & i_cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor, one bit per cycle LSB first, with a
// valid/ready handshake on both sides. Define SERIAL_ADDSUB_FLAGS_EN to build the flags.
module serial_addsub_ctrl
   import serial_alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             subSignal,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_sub;
   logic             w_sum;
   logic             w_cout;
   logic             w_last;

   addSub u_slice (
      .i_a    (r_a[0]),
      .i_b    (r_b[0]),
      .i_sub  (r_sub),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   assign w_last = (r_cnt == LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case can leave a signal unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      unique case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next_state = RUN;
         end
         RUN: begin
            if (w_last) w_next_state = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at bit 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_sub   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_sub   <= subSignal;
                  r_carry <= subSignal;
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_res   <= {w_sum, r_res[WIDTH-1:1]};
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_carry <= w_cout;
               if (!w_last) r_cnt <= r_cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign result = r_res;

`ifdef SERIAL_ADDSUB_FLAGS_EN
   logic r_cmsb;

   // Carry entering the MSB slice is the carry register during the last RUN cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                        r_cmsb <= 1'b0;
      else if (r_state == RUN && w_last) r_cmsb <= r_carry;
   end

   always_comb begin
      flags = 4'b0000;
      if (r_state == DONE) begin
         flags[NEG]  = r_res[WIDTH-1];
         flags[ZERO] = (r_res == '0);
         flags[OVF]  = r_cmsb ^ r_carry;
         flags[COUT] = r_carry;
      end
   end
`else
   assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: directed table, random ops against
// an arithmetic model, backpressure and mid-RUN reset sequences.
module tb_serial_addsub_ctrl;

   localparam int W = 64;

`ifdef SERIAL_ADDSUB_FLAGS_EN
   localparam logic [3:0] FMASK = 4'hF;
`else
   localparam logic [3:0] FMASK = 4'h0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         subSignal;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;

   int n_checks = 0;
   int n_errors = 0;

   serial_addsub_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .subSignal (subSignal),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] exp_res;
      logic [3:0]   exp_flags;
   } vec_t;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain two's-complement arithmetic with signed-overflow rules.
   function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      logic [W:0]   wide;
      logic [W-1:0] r;
      logic         cout, ovf;
      if (s) begin
         r    = a - b;
         cout = (a >= b);
         ovf  = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end else begin
         wide = {1'b0, a} + {1'b0, b};
         r    = wide[W-1:0];
         cout = wide[W];
         ovf  = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      return {r[W-1], (r == '0), ovf, cout, r};
   endfunction

   // Issue one op, scramble inputs during RUN, collect result, then consume it.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input string tag, output logic [W-1:0] res, output logic [3:0] fl);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      check({tag, " in_ready before issue"}, W'(in_ready), W'(1));
      A = a; B = b; subSignal = s; in_valid = 1'b1;
      @(posedge clk); n = 1; #1;
      while (!out_valid && n < 200) begin
         A = {$urandom, $urandom}; B = {$urandom, $urandom};
         subSignal = 1'($urandom); in_valid = 1'($urandom);
         if (n == W / 2) check({tag, " in_ready during RUN"}, W'(in_ready), W'(0));
         @(posedge clk); n++; #1;
      end
      in_valid = 1'b0;
      check({tag, " latency"}, W'(n), W'(W + 1));
      res = result;
      fl  = flags;
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
   endtask

   initial begin
      vec_t          vecs[6];
      logic [W-1:0]  res;
      logic [3:0]    fl;
      logic [W+3:0]  m;
      logic [W-1:0]  held;
      logic [W-1:0]  ra, rb;
      logic          rs;
      int            n;

      vecs[0] = '{64'd5, 64'd3, 1'b0, 64'd8, 4'b0000};
      vecs[1] = '{64'd7, 64'd7, 1'b1, 64'd0, 4'b0101};
      vecs[2] = '{64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
      vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1010};
      vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0101};
      vecs[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; subSignal = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset in_ready", W'(in_ready), W'(1));
      check("reset out_valid", W'(out_valid), W'(0));
      check("reset result", result, '0);
      check("reset flags", W'(flags), W'(0));
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].sub, $sformatf("vec%0d", i), res, fl);
         check($sformatf("vec%0d result", i), res, vecs[i].exp_res);
         check($sformatf("vec%0d flags", i), W'(fl), W'(vecs[i].exp_flags & FMASK));
         check($sformatf("vec%0d idle after consume", i), W'(in_ready), W'(1));
      end

      for (int i = 0; i < 20; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rs = 1'($urandom);
         if (i % 5 == 1) rb = ra;
         if (i % 5 == 2) ra = 64'h7FFF_FFFF_FFFF_FFFF;
         m = model(ra, rb, rs);
         do_op(ra, rb, rs, $sformatf("rnd%0d", i), res, fl);
         check($sformatf("rnd%0d result", i), res, m[W-1:0]);
         check($sformatf("rnd%0d flags", i), W'(fl), W'(m[W+3:W] & FMASK));
      end

      // Backpressure: hold DONE for 10 cycles while poking the inputs.
      @(negedge clk);
      A = 64'd100; B = 64'd23; subSignal = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 200) begin @(posedge clk); n++; #1; end
      check("bp reached DONE", W'(out_valid), W'(1));
      held = result;
      check("bp result", held, 64'd77);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         in_valid = ~in_valid; A = {$urandom, $urandom};
         @(posedge clk); #1;
         check($sformatf("bp hold%0d result", k), result, held);
         check($sformatf("bp hold%0d out_valid", k), W'(out_valid), W'(1));
         check($sformatf("bp hold%0d in_ready", k), W'(in_ready), W'(0));
      end
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      check("bp idle in_ready", W'(in_ready), W'(1));
      check("bp idle out_valid", W'(out_valid), W'(0));

      // out_ready pulsed while idle must not disturb anything.
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      check("idle out_ready in_ready", W'(in_ready), W'(1));

      // Reset while processing bit 30.
      @(negedge clk);
      A = 64'hDEAD_BEEF_1234_5678; B = 64'h0F0F_0F0F_0F0F_0F0F; subSignal = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      #1;
      check("midrst result", result, '0);
      check("midrst flags", W'(flags), W'(0));
      check("midrst out_valid", W'(out_valid), W'(0));
      check("midrst in_ready", W'(in_ready), W'(1));
      @(negedge clk); reset = 1'b0;
      do_op(64'd2, 64'd2, 1'b0, "postrst", res, fl);
      check("postrst result", res, 64'd4);
      check("postrst flags", W'(fl), W'(4'b0000));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 64, operand and result width in bits (WIDTH >= 2).
REQ-002 The block SHALL expose port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL expose port reset, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL expose port in_valid, input, 1, operands and op present.
REQ-005 The block SHALL expose port in_ready, output, 1, block accepts a new operation.
REQ-006 The block SHALL expose port A, input, WIDTH, first operand.
REQ-007 The block SHALL expose port B, input, WIDTH, second operand.
REQ-008 The block SHALL expose port subSignal, input, 1; 0 computes A+B, 1 computes A-B.
REQ-009 The block SHALL expose port out_valid, output, 1, result and flags valid.
REQ-010 The block SHALL expose port out_ready, input, 1, consumer takes the result.
REQ-011 The block SHALL expose port result, output, WIDTH, sum or difference modulo 2^WIDTH.
REQ-012 The block SHALL expose port flags, output, 4, {negative, zero, overflow, carryOut}.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 In IDLE, when in_valid is high: capture A, B, subSignal; clear the bit counter; load the carry register with subSignal; go to RUN.
REQ-015 Each RUN cycle SHALL process one bit, LSB first, through one add/sub bit slice fed by the A/B shift-register LSBs and the carry register.
REQ-016 In each RUN cycle, the sum bit SHALL shift into the result MSB, A/B SHALL shift right, and the carry register SHALL load the slice Cout.
REQ-017 RUN SHALL last exactly WIDTH cycles; after the cycle with counter = WIDTH-1, the FSM SHALL enter DONE. Acceptance-to-out_valid latency SHALL be WIDTH+1 cycles.
REQ-018 Bit counter SHALL be $clog2(WIDTH) bits wide and SHALL not wrap during RUN.
REQ-019 carryOut SHALL be the final carry register value; for subtraction, 1 means no borrow.
REQ-020 overflow SHALL be carry-into-MSB XOR carry-out-of-MSB; the carry into the MSB SHALL be registered during the last RUN cycle.
REQ-021 negative SHALL equal result[WIDTH-1]; zero SHALL be 1 if and only if result equals 0.
REQ-022 In DONE, result and flags SHALL hold stable until out_ready is high. The FSM SHALL then return to IDLE on that edge.
REQ-023 in_valid asserted in RUN or DONE SHALL be ignored. Operands SHALL be sampled only at IDLE acceptance, and input changes during RUN SHALL not affect result.
REQ-024 out_ready high outside DONE SHALL have no effect.
REQ-025 A new operation SHALL be accepted no earlier than the cycle after DONE exits, with a minimum issue interval of WIDTH+2 cycles.

Reset
REQ-026 While reset is high: state=IDLE; in_ready=1; out_valid=0; result=0; flags=0; counter, carry and shift registers=0.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation with no partial result visible. The first cycle after deassertion SHALL be IDLE.

Configuration
REQ-028 Macro SERIAL_ADDSUB_FLAGS_EN defined: flags SHALL be computed per REQ-019 to REQ-021.
REQ-029 Macro SERIAL_ADDSUB_FLAGS_EN undefined: flags SHALL be tied to 4'b0000 and the MSB-carry register SHALL not be built. Result and timing SHALL be unchanged.

Structure
REQ-030 Package serial_alu_pkg SHALL hold the state enum (IDLE, RUN, DONE), the flag index constants (NEG=3, ZERO=2, OVF=1, COUT=0), and DEFAULT_WIDTH=64.
REQ-031 The block SHALL instantiate exactly one existing add/sub bit slice, addSub, as its only sub-module. All other logic SHALL be local.

Verification
REQ-032 Add: A=5, B=3, sub=0 -> after 65 cycles, result=8, flags=0000.
REQ-033 Subtract equal: A=7, B=7, sub=1 -> result=0, flags=0101 (zero, carryOut).
REQ-034 Subtract with borrow: A=0, B=1, sub=1 -> result=all ones, flags=1000.
REQ-035 Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0 -> result=0x8000_0000_0000_0000, flags=1010.
REQ-036 Backpressure/ignore: hold out_ready=0 for 10 cycles in DONE while toggling in_valid/A -> result stable, no new accept. Then out_ready=1 -> IDLE the next cycle.
REQ-037 Reset mid-RUN at bit 30 -> all outputs 0 and in_ready=1. A next op of A=2, B=2, sub=0 -> result=4.
